keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Sequencer and event generator for the 4x4 mole keypad. It drives the active-low column lines and samples the active-low row lines after a settle time. Whole-matrix snapshots are debounced across consecutive scan frames, and each new key press is delivered as one key code over a valid/ready handshake to the game FSM. It replaces free-running scan logic and keeps per-key debounced state for the game and display.

## Interface
- SETTLE, 3: extra cycles each column is driven before its row sample (column held SETTLE+1 cycles)
- DEBOUNCE, 2: frames that must match the previous frame before a snapshot commits (DEBOUNCE+1 identical consecutive frames; 1..15)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- row  input  4  keypad rows, active-low (0 = pressed in driven column)
- col  output  4  keypad column drive, one-hot-low
- key_map  output  16  debounced pressed state, bit index = row*4+col, 1 = pressed
- key_valid  output  1  event register holds an unconsumed press
- key_code  output  4  {row[1:0], col[1:0]} of the event; stable while key_valid && !key_ready
- key_ready  input  1  consumer accepts event when key_valid && key_ready at a rising edge
- overflow  output  1  one-cycle pulse: a new press was lost

## Operation
- Scan counter: column index c (0..3) and settle count s (0..SETTLE). col = ~(1<<c). s counts up; at s==SETTLE, sample row into frame bits [r*4+c] = ~row[r], then s<=0 and c<=c+1 (wrap 3->0). A frame is 4*(SETTLE+1) cycles.
- Frame end is the sample edge of c==3. At that edge the completed frame (including the current row sample) is compared with prev_frame:
  - equal: stable_cnt <= min(stable_cnt+1, DEBOUNCE)
  - different: stable_cnt <= 0
  - prev_frame <= completed frame
- Commit: at a frame-end edge where the frame equals prev_frame and stable_cnt+1 >= DEBOUNCE, key_map <= frame. On the same edge pending <= pending | (frame & ~key_map).
- Releases clear key_map bits and generate no event.
- Event register: when empty, or consumed this cycle, it loads the lowest-index set bit of pending. That bit is cleared from pending on the same edge. key_valid reflects register occupancy.
- overflow pulses for one cycle when a commit sets a newly pressed bit that is already set in pending or equal to the held key_code. The pending state is unchanged; the press is merged.
- Simultaneous commit and consume: both apply. The load uses pending after the commit's OR.
- Reset (asserted low, asynchronous):
  - col=4'b1110, c=0, s=0
  - frame, prev_frame, key_map, pending = 0; stable_cnt=0
  - key_valid=0, key_code=0, overflow=0
- Scanning restarts at column 0 on the first edge after deassertion.
- Reset mid-event discards pending and held events. Keys still held after reset are reported again as new presses once debounced.

## Timing
- key_map updates on the frame-end edge of the (DEBOUNCE+1)th identical consecutive frame. The first frame after reset compares against all-zero prev_frame.
- key_valid rises on the edge after the commit edge if the event register was empty (latency 1 cycle from commit).
- With the consumer holding key_ready=1, one event is delivered per cycle.
- Mid-frame row changes only affect columns sampled afterwards. No partial-frame commit is possible.
- col changes only on sample edges and is glitch-free (registered).

## Test plan
- Reset: drive rst=0 mid-scan -> col=4'b1110, key_valid=0, key_map=0 asynchronously. Release -> col=4'b1110 held exactly SETTLE+1 cycles, then 4'b1101, 4'b1011, 4'b0111, wrap.
- Single press (SETTLE=1, DEBOUNCE=2): hold row2 low only while col=4'b1101, for all frames -> key_map=16'h0200 at the 3rd frame end. key_valid=1, key_code=9 one cycle later. key_ready=1 -> key_valid=0 next cycle, with no repeat while held.
- Bounce: press key 0 for 1 frame, release 1 frame, press 1 frame -> key_map stays 0, no event. Then hold 3 frames -> single event code 0.
- Multi-press with backpressure: keys 5 and 3 debounced in the same frame, key_ready=0 -> key_code=3 stable while held. Assert key_ready -> code 3 accepted, then code 5 next cycle, then key_valid=0.
- Overflow: key 7 event unconsumed; release key 7 (debounced), re-press (debounced) -> overflow pulses 1 cycle, key_code stays 7, and only one event is delivered.
- Release: after press of key 15 is consumed, release -> key_map bit 15 clears after 3 identical frames, key_valid stays 0.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with whole-frame debounce
// and lowest-index-first press events over a valid/ready handshake.
module keypad_scan_ctrl #(
   parameter int SETTLE   = 3,
   parameter int DEBOUNCE = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [15:0] key_map,
   output logic        key_valid,
   output logic [3:0]  key_code,
   input  logic        key_ready,
   output logic        overflow
);
   localparam int SW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
   logic [1:0]    c;
   logic [SW-1:0] s;
   logic [3:0]    stable_cnt, pick_code;
   logic [15:0]   frame, prev_frame, pending, cur_frame, new_press, held, pend_or, src, pick, pend_nxt;
   logic          sample, frame_end, commit, load, ovf_nxt;
   always_comb begin
      sample = s == SW'(SETTLE);
      frame_end = sample && c == 2'd3;
      cur_frame = frame;
      for (int r = 0; r < 4; r++)
         if (sample) cur_frame[r*4 + int'(c)] = ~row[r];
      commit = frame_end && cur_frame == prev_frame && ({1'b0, stable_cnt} + 5'd1 >= 5'(DEBOUNCE));
      // a re-press of the key still waiting in the event register is merged, not queued
      held = key_valid && !key_ready ? 16'd1 << key_code : 16'd0;
      new_press = commit ? cur_frame & ~key_map : 16'd0;
      ovf_nxt = |(new_press & (pending | held));
      pend_or = pending | (new_press & ~held);
      load = !key_valid || key_ready;
      src = key_valid ? pend_or : pending;
      pick = src & (~src + 16'd1);
      pick_code = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (src[i]) pick_code = 4'(i);
      pend_nxt = load ? pend_or & ~pick : pend_or;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         c <= 2'd0;
         s <= '0;
         col <= 4'b1110;
         frame <= '0;
         prev_frame <= '0;
         key_map <= '0;
         pending <= '0;
         stable_cnt <= '0;
         key_valid <= 1'b0;
         key_code <= '0;
         overflow <= 1'b0;
      end else begin
         s <= sample ? '0 : s + SW'(1);
         if (sample) begin
            c <= c + 2'd1;
            col <= ~(4'b0001 << (c + 2'd1));
         end
         frame <= cur_frame;
         if (frame_end) begin
            prev_frame <= cur_frame;
            stable_cnt <= cur_frame != prev_frame ? 4'd0 :
                          stable_cnt >= 4'(DEBOUNCE) ? stable_cnt : stable_cnt + 4'd1;
         end
         if (commit) key_map <= cur_frame;
         pending <= pend_nxt;
         overflow <= ovf_nxt;
         if (load) begin
            key_valid <= |src;
            if (|src) key_code <= pick_code;
         end
      end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: keypad matrix model, frame-level vector table and
// an event scoreboard checked on every handshake.
module tb_keypad_scan_ctrl;
   logic clk = 1'b0, rst = 1'b0, key_ready = 1'b0;
   logic [3:0]  row, col, key_code, mon_e;
   logic [15:0] key_map, keys = 16'h0;
   logic        key_valid, overflow;
   int n_cmp = 0, n_err = 0;
   logic [3:0] exp_q[$];
   typedef struct { logic [15:0] keys; logic [15:0] map; } vec_t;
   vec_t tv[18];
   logic [3:0] cs[8];

   always #5 clk = ~clk;

   keypad_scan_ctrl #(.SETTLE(1), .DEBOUNCE(2)) dut (
      .clk(clk), .rst(rst), .row(row), .col(col), .key_map(key_map),
      .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready), .overflow(overflow)
   );

   // pressed key pulls its row low while its column is driven
   always_comb begin
      row = 4'hF;
      for (int cc = 0; cc < 4; cc++)
         if (!col[cc])
            for (int r = 0; r < 4; r++)
               if (keys[r*4 + cc]) row[r] = 1'b0;
   end

   always @(negedge clk)
      if (rst && key_valid && key_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL event: got code %0d, expected no event", key_code);
         end else begin
            mon_e = exp_q.pop_front();
            if (key_code !== mon_e) begin
               n_err++;
               $display("FAIL event: got code %0d, expected %0d", key_code, mon_e);
            end
         end
      end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic frame_chk(input string nm, input logic [15:0] k, input logic [15:0] m,
                            input logic v, input logic o);
      keys = k;
      repeat (8) @(posedge clk);
      #1;
      chk({nm, " key_map"}, key_map, m);
      chk({nm, " key_valid"}, 16'(key_valid), 16'(v));
      chk({nm, " overflow"}, 16'(overflow), 16'(o));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] pm;
      tv = '{'{16'h0200, 16'h0000}, '{16'h0200, 16'h0000}, '{16'h0200, 16'h0200}, '{16'h0200, 16'h0200},
             '{16'h0000, 16'h0200}, '{16'h0000, 16'h0200}, '{16'h0000, 16'h0000},
             '{16'h0001, 16'h0000}, '{16'h0000, 16'h0000}, '{16'h0001, 16'h0000},
             '{16'h0001, 16'h0000}, '{16'h0001, 16'h0001},
             '{16'h8000, 16'h0001}, '{16'h8000, 16'h0001}, '{16'h8000, 16'h8000},
             '{16'h0000, 16'h8000}, '{16'h0000, 16'h8000}, '{16'h0000, 16'h0000}};
      cs = '{4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b1110};
      key_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst col", 16'(col), 16'h000E);
      chk("rst key_map", key_map, 16'h0);
      chk("rst key_valid", 16'(key_valid), 16'h0);
      chk("rst key_code", 16'(key_code), 16'h0);
      chk("rst overflow", 16'(overflow), 16'h0);
      rst = 1'b1;
      chk("col_seq 0", 16'(col), 16'h000E);
      for (int k = 0; k < 8; k++) begin
         step;
         chk("col_seq", 16'(col), 16'(cs[k]));
      end
      pm = 16'h0;
      for (int i = 0; i < 18; i++) begin
         frame_chk("table", tv[i].keys, tv[i].map, 1'b0, 1'b0);
         for (int b = 0; b < 16; b++)
            if (tv[i].map[b] && !pm[b]) exp_q.push_back(4'(b));
         pm = tv[i].map;
      end
      key_ready = 1'b0;
      frame_chk("bp", 16'h0028, 16'h0000, 1'b0, 1'b0);
      frame_chk("bp", 16'h0028, 16'h0000, 1'b0, 1'b0);
      frame_chk("bp", 16'h0028, 16'h0028, 1'b0, 1'b0);
      exp_q.push_back(4'd3);
      exp_q.push_back(4'd5);
      step;
      chk("bp valid", 16'(key_valid), 16'h1);
      chk("bp code", 16'(key_code), 16'd3);
      repeat (3) step;
      chk("bp code held", 16'(key_code), 16'd3);
      chk("bp valid held", 16'(key_valid), 16'h1);
      key_ready = 1'b1;
      repeat (4) step;
      chk("bp drained", 16'(key_valid), 16'h0);
      key_ready = 1'b0;
      frame_chk("ovf", 16'h0080, 16'h0028, 1'b0, 1'b0);
      frame_chk("ovf", 16'h0080, 16'h0028, 1'b0, 1'b0);
      frame_chk("ovf", 16'h0080, 16'h0080, 1'b0, 1'b0);
      exp_q.push_back(4'd7);
      frame_chk("ovf rel", 16'h0000, 16'h0080, 1'b1, 1'b0);
      frame_chk("ovf rel", 16'h0000, 16'h0080, 1'b1, 1'b0);
      frame_chk("ovf rel", 16'h0000, 16'h0000, 1'b1, 1'b0);
      chk("ovf code", 16'(key_code), 16'd7);
      frame_chk("ovf re", 16'h0080, 16'h0000, 1'b1, 1'b0);
      frame_chk("ovf re", 16'h0080, 16'h0000, 1'b1, 1'b0);
      frame_chk("ovf re", 16'h0080, 16'h0080, 1'b1, 1'b1);
      step;
      chk("ovf pulse end", 16'(overflow), 16'h0);
      chk("ovf code kept", 16'(key_code), 16'd7);
      key_ready = 1'b1;
      repeat (7) step;
      chk("ovf single event", 16'(key_valid), 16'h0);
      key_ready = 1'b0;
      frame_chk("ar", 16'h0002, 16'h0080, 1'b0, 1'b0);
      frame_chk("ar", 16'h0002, 16'h0080, 1'b0, 1'b0);
      frame_chk("ar", 16'h0002, 16'h0002, 1'b0, 1'b0);
      step;
      chk("ar valid", 16'(key_valid), 16'h1);
      chk("ar code", 16'(key_code), 16'd1);
      repeat (3) step;
      #3 rst = 1'b0;
      #1;
      chk("ar col", 16'(col), 16'h000E);
      chk("ar key_map", key_map, 16'h0);
      chk("ar key_valid", 16'(key_valid), 16'h0);
      chk("ar key_code", 16'(key_code), 16'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      key_ready = 1'b1;
      frame_chk("ar again", 16'h0002, 16'h0000, 1'b0, 1'b0);
      frame_chk("ar again", 16'h0002, 16'h0000, 1'b0, 1'b0);
      frame_chk("ar again", 16'h0002, 16'h0002, 1'b0, 1'b0);
      exp_q.push_back(4'd1);
      frame_chk("ar again", 16'h0002, 16'h0002, 1'b0, 1'b0);
      chk("events outstanding", 16'(exp_q.size()), 16'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
